// File: rtl/fft_input_framer.sv
// Packs a serial valid/ready stream of complex samples into 4-sample frames through a
// ping-pong buffer and hands each frame to the FFT with a one-cycle start pulse.
module fft_input_framer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic [DATA_W-1:0] x0_real,
  output logic [DATA_W-1:0] x1_real,
  output logic [DATA_W-1:0] x2_real,
  output logic [DATA_W-1:0] x3_real,
  output logic [DATA_W-1:0] x0_imag,
  output logic [DATA_W-1:0] x1_imag,
  output logic [DATA_W-1:0] x2_imag,
  output logic [DATA_W-1:0] x3_imag,
  output logic              start,
  input  logic              fft_done,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_issued
);

  localparam int unsigned FRAME_N = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] buf_real [2][FRAME_N];
  logic [DATA_W-1:0] buf_imag [2][FRAME_N];
  logic [DATA_W-1:0] x_real [FRAME_N];
  logic [DATA_W-1:0] x_imag [FRAME_N];

  logic [1:0]       full, full_n;
  logic             wr_sel, wr_sel_n, rd_sel;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_fire, wr_last;
  logic             load, rd_release, start_n;

  assign wr_fire = in_valid & in_ready;
  assign wr_last = wr_fire && (wr_idx == IDX_W'(FRAME_N - 1));

  // Buffer occupancy; release and completion never target the same buffer.
  always_comb begin
    full_n   = full;
    wr_sel_n = wr_sel;
    if (rd_release) full_n[rd_sel] = 1'b0;
    if (wr_last) begin
      full_n[wr_sel] = 1'b1;
      wr_sel_n       = ~wr_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    start_n    = 1'b0;
    load       = 1'b0;
    rd_release = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_sel]) begin
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        start_n = 1'b1;
        state_n = BUSY;
      end
      BUSY: begin
        if (fft_done) begin
          rd_release = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Sample storage carries no reset: contents are only read once marked full.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      buf_real[wr_sel][wr_idx] <= in_real;
      buf_imag[wr_sel][wr_idx] <= in_imag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full          <= 2'b00;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      wr_idx        <= '0;
      in_ready      <= 1'b0;
      start         <= 1'b0;
      busy          <= 1'b0;
      frames_issued <= '0;
      for (int k = 0; k < FRAME_N; k++) begin
        x_real[k] <= '0;
        x_imag[k] <= '0;
      end
    end else begin
      full     <= full_n;
      wr_sel   <= wr_sel_n;
      in_ready <= ~full_n[wr_sel_n];
      start    <= start_n;
      busy     <= (state_n != IDLE);
      if (wr_fire)    wr_idx <= wr_idx + IDX_W'(1);
      if (rd_release) rd_sel <= ~rd_sel;
      if (start_n)    frames_issued <= frames_issued + CNT_W'(1);
      if (load) begin
        for (int k = 0; k < FRAME_N; k++) begin
          x_real[k] <= buf_real[rd_sel][k];
          x_imag[k] <= buf_imag[rd_sel][k];
        end
      end
    end
  end

  assign x0_real = x_real[0];
  assign x1_real = x_real[1];
  assign x2_real = x_real[2];
  assign x3_real = x_real[3];
  assign x0_imag = x_imag[0];
  assign x1_imag = x_imag[1];
  assign x2_imag = x_imag[2];
  assign x3_imag = x_imag[3];

endmodule

// File: tb/tb_fft_input_framer.sv
// Scoreboard bench for fft_input_framer: a sample-queue model predicts frames, a monitor
// checks every start pulse, and a responder plays the role of the FFT.
module tb_fft_input_framer;

  typedef struct packed {
    logic [3:0][31:0] re;
    logic [3:0][31:0] im;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_real = '0;
  logic [31:0] in_imag = '0;
  logic [31:0] x0_real, x1_real, x2_real, x3_real;
  logic [31:0] x0_imag, x1_imag, x2_imag, x3_imag;
  logic        start;
  logic        fft_done = 1'b0;
  logic        busy;
  logic [15:0] frames_issued;

  int total = 0;
  int bad = 0;

  logic [31:0] pre[$];
  logic [31:0] pim[$];
  frame_t      exp_q[$];
  frame_t      cur_frame;
  int          n_model = 0;
  int          n_xfer = 0;
  bit          auto_done = 1'b1;
  bit          rand_delay = 1'b0;
  int          d_resp;

  fft_input_framer #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag),
    .x0_real(x0_real), .x1_real(x1_real), .x2_real(x2_real), .x3_real(x3_real),
    .x0_imag(x0_imag), .x1_imag(x1_imag), .x2_imag(x2_imag), .x3_imag(x3_imag),
    .start(start), .fft_done(fft_done), .busy(busy), .frames_issued(frames_issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic frame_t x_now();
    frame_t f;
    f.re = {x3_real, x2_real, x1_real, x0_real};
    f.im = {x3_imag, x2_imag, x1_imag, x0_imag};
    return f;
  endfunction

  // Reference: every 4 accepted samples, in arrival order, form one frame.
  task automatic model_push(input logic [31:0] re, input logic [31:0] im);
    frame_t f;
    pre.push_back(re);
    pim.push_back(im);
    n_xfer++;
    if (pre.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        f.re[k] = pre[k];
        f.im[k] = pim[k];
      end
      exp_q.push_back(f);
      pre.delete();
      pim.delete();
    end
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] im);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_push(re, im);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    fft_done = 1'b0;
    pre.delete();
    pim.delete();
    exp_q.delete();
    n_model = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frames", 64'(frames_issued), 64'd0);
    chk("rst_x_real", {x3_real, x0_real}, 64'd0);
    chk("rst_x_imag", {x3_imag, x0_imag}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size() != 0 || busy), 64'd0);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_busy", 64'(busy), 64'd1);
  endtask

  // Monitor: each start pulse must present the oldest predicted frame.
  initial forever begin
    @(negedge clk);
    if (!rst && start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 64'(start), 64'd0);
      end else begin
        frame_t e, a;
        e = exp_q.pop_front();
        a = x_now();
        n_model++;
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("x%0d_real", k), 64'(a.re[k]), 64'(e.re[k]));
          chk($sformatf("x%0d_imag", k), 64'(a.im[k]), 64'(e.im[k]));
        end
        chk("frames_issued", 64'(frames_issued), 64'(16'(n_model)));
        cur_frame = e;
      end
    end
  end

  // FFT stand-in: acknowledges each frame after a delay, checking the frame held steady.
  initial forever begin
    @(negedge clk);
    if (start && auto_done && !rst) begin
      d_resp = rand_delay ? int'($urandom_range(1, 6)) : 5;
      repeat (d_resp) @(negedge clk);
      chk("x_hold", 64'(x_now() == cur_frame), 64'd1);
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
    end
  end

  initial begin
    int base;
    int n;
    logic [31:0] r, i;

    do_reset();

    for (int k = 0; k < 4; k++) send(32'h0001_0000, 32'h0);
    drain();
    chk("t2_frames", 64'(frames_issued), 64'd1);

    for (int k = 1; k <= 4; k++) send(32'(k) * 32'h0001_0000, 32'(k) * 32'h100);
    wait_busy();
    chk("t3_x0_real", 64'(x0_real), 64'h0001_0000);
    chk("t3_x3_real", 64'(x3_real), 64'h0004_0000);
    chk("t3_x3_imag", 64'(x3_imag), 64'h0000_0400);
    drain();

    // Both buffers fill while the FFT never finishes the first frame.
    auto_done = 1'b0;
    base = n_xfer;
    n = n_model;
    fork
      for (int k = 0; k < 12; k++) send(32'(k + 1) << 16, 32'(k));
    join_none
    repeat (40) @(negedge clk);
    chk("t4_xfers_stalled", 64'(n_xfer - base), 64'd8);
    chk("t4_in_ready_low", 64'(in_ready), 64'd0);
    chk("t4_one_start", 64'(n_model - n), 64'd1);
    fft_done = 1'b1;
    auto_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    chk("t4_in_ready_back", 64'(in_ready), 64'd1);
    chk("t4_no_start_1", 64'(start), 64'd0);
    @(negedge clk);
    chk("t4_no_start_2", 64'(start), 64'd0);
    @(negedge clk);
    chk("t4_restart", 64'(start), 64'd1);
    n = 0;
    while (n_xfer - base < 12 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t4_all_sent", 64'(n_xfer - base), 64'd12);
    drain();

    send(32'h1111_1111, 32'h2222_2222);
    send(32'h3333_3333, 32'h4444_4444);
    do_reset();
    for (int k = 0; k < 4; k++) send(32'h0002_0000, 32'h0);
    drain();
    chk("t5_frames", 64'(frames_issued), 64'd1);

    n = int'(frames_issued);
    @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_frames", 64'(frames_issued), 64'(n));

    rand_delay = 1'b1;
    for (int k = 0; k < 48; k++) begin
      r = $urandom;
      i = $urandom;
      send(r, i);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    chk("final_frames", 64'(frames_issued), 64'(16'(n_model)));
    chk("final_partial", 64'(pre.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
